sum_tx_streamer: RTL
====================

SUM_TX_STREAMER -- requirements
Module: sum_tx_streamer

Interface
REQ-001 Parameter DEPTH, default 768, number of 40-bit sum words per frame.
REQ-002 Parameter ADDR_W, default 10, sum RAM address width.
REQ-003 Parameter RD_LAT, default 2, sum RAM read latency in clk cycles (read data valid RD_LAT cycles after rd_en/rd_addr are sampled).
REQ-004 Parameter SYNC, default 8'hA5, frame header byte.
REQ-005 clk  input  1  single clock for all logic (100 MHz PLL output); one clock, no other clock domains.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  level or pulse; rising-edge detected inside the block, begins one frame.
REQ-008 rd_en  output  1  sum RAM read enable.
REQ-009 rd_addr  output  ADDR_W  sum RAM read address.
REQ-010 rd_data  input  40  sum RAM read data.
REQ-011 tx_start  output  1  one-cycle request to the UART TX module.
REQ-012 tx_data  output  8  byte to transmit; stable from tx_start until tx_busy falls.
REQ-013 tx_busy  input  1  UART TX busy.
REQ-014 busy  output  1  high while a frame is in progress.
REQ-015 done  output  1  one-cycle pulse after the last frame byte completes.
REQ-016 checksum  output  8  running XOR of data bytes; holds final value after done.

Function
REQ-017 Frame: SYNC byte, then DEPTH words each sent as 5 bytes MSB first ([39:32],[31:24],[23:16],[15:8],[7:0]), then one checksum byte; total 5*DEPTH+2 bytes (3842 at default).
REQ-018 Checksum = XOR of all 5*DEPTH data bytes only; SYNC excluded; cleared at frame start.
REQ-019 States: IDLE, HDR, FETCH, WAIT_RD, SEND, WAIT_HI, WAIT_LO, NEXT, CSUM, DONE.
REQ-020 IDLE -> HDR on start rising edge; start edges while busy=1 are ignored.
REQ-021 FETCH drives rd_en=1, rd_addr=word index for one cycle; WAIT_RD counts RD_LAT cycles then latches rd_data into a 40-bit shift register.
REQ-022 SEND: only when tx_busy=0, assert tx_start for exactly one cycle with tx_data valid in that same cycle; otherwise hold in SEND.
REQ-023 WAIT_HI waits for tx_busy=1; WAIT_LO then waits for tx_busy=0; next byte only after WAIT_LO exits (no tx_start while tx_busy=1).
REQ-024 After byte 5 of a word, NEXT increments word index; index DEPTH-1 -> CSUM, else -> FETCH; no wrap of rd_addr past DEPTH-1.
REQ-025 CSUM sends checksum via the same SEND/WAIT_HI/WAIT_LO handshake, then DONE asserts done for one cycle and returns to IDLE.
REQ-026 busy=1 in every state except IDLE; rd_en=0 outside FETCH.
REQ-027 Word index counter ADDR_W bits; byte counter 3 bits (0..4).

Reset
REQ-028 reset low asynchronously forces: state IDLE, rd_en 0, rd_addr 0, tx_start 0, tx_data 0, busy 0, done 0, checksum 0, counters 0, start edge detector cleared.
REQ-029 reset asserted mid-frame aborts the frame with no further tx_start; new frame needs a fresh start edge after reset release.

Structure
REQ-030 Shared package holds the state enumeration constants, default DEPTH/ADDR_W/RD_LAT, and SYNC value, for reuse by the beamformer controller.
REQ-031 One sub-module, tx_byte_handshake, implements SEND/WAIT_HI/WAIT_LO for a single byte (inputs byte, go; outputs tx_start, tx_data, byte_done).

Verification
REQ-032 DEPTH=4, RAM words 0x0102030405, 0x1112131415, 0, 0xFFFFFFFFFF, start pulse -> bytes A5,01,02,03,04,05,11..15,00x5,FFx5, checksum 0x01^0x00^0xFF-derived value (computed by model), done pulse once, 22 bytes total.
REQ-033 TX model holding tx_busy=1 for 100 cycles per byte -> exactly one tx_start per byte, never while tx_busy=1, tx_data stable throughout.
REQ-034 RD_LAT=2 with RAM model returning data exactly 2 cycles after rd_en -> correct word latched; RD_LAT=3 variant also correct.
REQ-035 start re-pulsed during byte 7 -> ignored, frame completes normally, single done.
REQ-036 reset low during word 2 -> all outputs reset values within same cycle, no tx_start after; subsequent start -> full correct frame from SYNC.
REQ-037 Default DEPTH=768, all words 0x0000000001 -> 3842 bytes, checksum 0x00 (768 even), last rd_addr 767.

Source files
------------

// File: rtl/sum_tx_streamer_pkg.sv
// Shared constants and state encodings for the sum RAM -> UART frame streamer.
// Kept separate so the beamformer controller can decode the same state values.
package sum_tx_streamer_pkg;

    localparam int         DEF_DEPTH  = 768;
    localparam int         DEF_ADDR_W = 10;
    localparam int         DEF_RD_LAT = 2;
    localparam logic [7:0] DEF_SYNC   = 8'hA5;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_HDR     = 4'd1,
        ST_FETCH   = 4'd2,
        ST_WAIT_RD = 4'd3,
        ST_SEND    = 4'd4,
        ST_WAIT_HI = 4'd5,
        ST_WAIT_LO = 4'd6,
        ST_NEXT    = 4'd7,
        ST_CSUM    = 4'd8,
        ST_DONE    = 4'd9
    } state_t;

    // Which part of the frame the byte currently in flight belongs to.
    typedef enum logic [1:0] {
        K_HDR  = 2'd0,
        K_DATA = 2'd1,
        K_CSUM = 2'd2
    } byte_kind_t;

endpackage

// File: rtl/sum_tx_streamer_tx_byte_handshake.sv
// One-byte UART TX handshake: request when the UART is idle, then wait for
// busy to rise and fall again before reporting the byte as finished.
module tx_byte_handshake
    import sum_tx_streamer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_byte,
    input  logic       go,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       byte_done,
    output logic [3:0] phase
);

    state_t     hs_state;
    state_t     hs_state_n;
    logic       load;
    logic [7:0] data_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hs_state <= ST_IDLE;
            data_q   <= '0;
        end else begin
            hs_state <= hs_state_n;
            if (load) data_q <= tx_byte;
        end
    end

    // go is accepted in the cycle byte_done fires so back-to-back bytes need no idle gap.
    always_comb begin
        hs_state_n = hs_state;
        tx_start   = 1'b0;
        byte_done  = 1'b0;
        load       = 1'b0;
        unique case (hs_state)
            ST_IDLE: begin
                if (go) begin
                    load       = 1'b1;
                    hs_state_n = ST_SEND;
                end
            end
            ST_SEND: begin
                if (!tx_busy) begin
                    tx_start   = 1'b1;
                    hs_state_n = ST_WAIT_HI;
                end
            end
            ST_WAIT_HI: begin
                if (tx_busy) hs_state_n = ST_WAIT_LO;
            end
            ST_WAIT_LO: begin
                if (!tx_busy) begin
                    byte_done  = 1'b1;
                    hs_state_n = ST_IDLE;
                    if (go) begin
                        load       = 1'b1;
                        hs_state_n = ST_SEND;
                    end
                end
            end
            default: hs_state_n = ST_IDLE;
        endcase
    end

    assign tx_data = data_q;
    assign phase   = hs_state;

endmodule

// File: rtl/sum_tx_streamer.sv
// Streams one frame (SYNC, DEPTH 40-bit sums MSB first, XOR checksum) from the
// sum RAM to a byte-wide UART transmitter, one frame per start rising edge.
module sum_tx_streamer
    import sum_tx_streamer_pkg::*;
#(
    parameter int         DEPTH  = DEF_DEPTH,
    parameter int         ADDR_W = DEF_ADDR_W,
    parameter int         RD_LAT = DEF_RD_LAT,
    parameter logic [7:0] SYNC   = DEF_SYNC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [39:0]       rd_data,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_busy,
    output logic              busy,
    output logic              done,
    output logic [7:0]        checksum,
    output logic [3:0]        state_dbg
);

    localparam int                CNT_W    = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);
    localparam logic [CNT_W-1:0]  LAT_CNT  = CNT_W'(RD_LAT);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_t            state;
    state_t            state_n;
    byte_kind_t        kind;
    byte_kind_t        kind_n;
    logic [ADDR_W-1:0] word_idx;
    logic [2:0]        byte_cnt;
    logic [CNT_W-1:0]  rd_cnt;
    logic [39:0]       shreg;
    logic [7:0]        csum;
    logic              start_q;
    logic              start_rise;

    logic              go;
    logic [7:0]        hs_byte;
    logic              byte_done;
    logic [3:0]        hs_phase;
    logic              clr_frame;
    logic              ld_word;
    logic              shift_byte;
    logic              inc_word;

    assign start_rise = start & ~start_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            kind     <= K_HDR;
            word_idx <= '0;
            byte_cnt <= '0;
            rd_cnt   <= '0;
            shreg    <= '0;
            csum     <= '0;
            start_q  <= 1'b0;
        end else begin
            state   <= state_n;
            kind    <= kind_n;
            start_q <= start;
            if (clr_frame)     word_idx <= '0;
            else if (inc_word) word_idx <= word_idx + 1'b1;
            if (ld_word)         byte_cnt <= '0;
            else if (shift_byte) byte_cnt <= byte_cnt + 3'd1;
            if (state == ST_FETCH)        rd_cnt <= CNT_W'(1);
            else if (state == ST_WAIT_RD) rd_cnt <= rd_cnt + 1'b1;
            if (ld_word)         shreg <= {rd_data[31:0], 8'h00};
            else if (shift_byte) shreg <= {shreg[31:0], 8'h00};
            // Only data bytes feed the checksum; SYNC and the checksum byte do not.
            if (clr_frame)                  csum <= '0;
            else if (ld_word || shift_byte) csum <= csum ^ hs_byte;
        end
    end

    always_comb begin
        state_n    = state;
        kind_n     = kind;
        go         = 1'b0;
        hs_byte    = shreg[39:32];
        clr_frame  = 1'b0;
        ld_word    = 1'b0;
        shift_byte = 1'b0;
        inc_word   = 1'b0;
        rd_en      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start_rise) begin
                    clr_frame = 1'b1;
                    state_n   = ST_HDR;
                end
            end
            ST_HDR: begin
                go      = 1'b1;
                hs_byte = SYNC;
                kind_n  = K_HDR;
                state_n = ST_SEND;
            end
            ST_FETCH: begin
                rd_en   = 1'b1;
                state_n = ST_WAIT_RD;
            end
            ST_WAIT_RD: begin
                if (rd_cnt == LAT_CNT) begin
                    ld_word = 1'b1;
                    go      = 1'b1;
                    hs_byte = rd_data[39:32];
                    kind_n  = K_DATA;
                    state_n = ST_SEND;
                end
            end
            ST_SEND: begin
                if (byte_done) begin
                    unique case (kind)
                        K_HDR:  state_n = ST_FETCH;
                        K_DATA: begin
                            if (byte_cnt == 3'd4) begin
                                state_n = ST_NEXT;
                            end else begin
                                shift_byte = 1'b1;
                                go         = 1'b1;
                            end
                        end
                        K_CSUM:  state_n = ST_DONE;
                        default: state_n = ST_IDLE;
                    endcase
                end
            end
            ST_NEXT: begin
                if (word_idx == LAST_IDX) begin
                    state_n = ST_CSUM;
                end else begin
                    inc_word = 1'b1;
                    state_n  = ST_FETCH;
                end
            end
            ST_CSUM: begin
                go      = 1'b1;
                hs_byte = csum;
                kind_n  = K_CSUM;
                state_n = ST_SEND;
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    tx_byte_handshake u_hs (
        .clk       (clk),
        .reset     (reset),
        .tx_byte   (hs_byte),
        .go        (go),
        .tx_busy   (tx_busy),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .byte_done (byte_done),
        .phase     (hs_phase)
    );

    assign rd_addr  = word_idx;
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);
    assign checksum = csum;
    // While a byte is in flight the handshake phase gives the finer-grained state.
    assign state_dbg = (state == ST_SEND && hs_phase != ST_IDLE) ? hs_phase : state;

endmodule
